mssd_header_ctrl: RTL and testbench

- Serial front-end and control FSM for the MSSD serial demultiplexer.
- Detects a start bit on the serial line, shifts in a 2-bit destination port and a 4-bit payload length, then drives the downstream data-transfer down-counter (ldcntD/cntD, NumData, coD).
- Routes each payload bit to one of four output channels until the counter reports zero.

---
 rtl/mssd_header_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mssd_header_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mssd_header_ctrl.sv
// mssd_header_ctrl
// Serial front-end and control FSM for the MSSD serial demultiplexer.
// A frame is, MSB first: start bit (0), PORT_W destination-port bits,
// SIZE_W payload-length bits, then NumData payload bits. The header is
// shifted in one bit per clkEn. The block then loads the external
// data-transfer down-counter and routes each payload bit to the selected
// channel until that counter reports zero.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   clkEn     in   serial bit-rate enable (one serial bit per enabled clk)
//   sin       in   serial input line, idles high
//   coD       in   count-zero flag from the data-transfer counter
//   ldcntD    out  counter load strobe (LOAD state)
//   cntD      out  counter count-down enable (DATA state, counter not at zero)
//   NumData   out  captured payload length, counter load value
//   port_sel  out  captured destination port
//   dout      out  routed serial data, one bit per channel
//   valid     out  per-channel bit-valid strobe
//   busy      out  high whenever the FSM is not in IDLE
//   done      out  one-clk pulse at end of frame
module mssd_header_ctrl #(
  parameter int PORT_W = 2,
  parameter int SIZE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              sin,
  input  logic              coD,
  output logic              ldcntD,
  output logic              cntD,
  output logic [SIZE_W-1:0] NumData,
  output logic [PORT_W-1:0] port_sel,
  output logic [3:0]        dout,
  output logic [3:0]        valid,
  output logic              busy,
  output logic              done
);

  localparam int NUM_CH = 4;
  // Last bit index of each header field, in bit-counter width.
  localparam logic [2:0] PORT_LAST = 3'(PORT_W - 1);
  localparam logic [2:0] SIZE_LAST = 3'(SIZE_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PORT = 3'd1,
    SIZE = 3'd2,
    LOAD = 3'd3,
    DATA = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] bit_cnt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Header shift registers and bit counter; they only move on enabled
  // serial bits, so a clkEn stall holds the whole header context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_sel <= {PORT_W{1'b0}};
      NumData  <= {SIZE_W{1'b0}};
      bit_cnt  <= 3'd0;
    end else if (clkEn) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            bit_cnt <= 3'd0;
          end
        end
        PORT: begin
          port_sel <= {port_sel[PORT_W-2:0], sin};
          // Clearing on the last port bit gives SIZE a fresh count.
          if (bit_cnt == PORT_LAST) begin
            bit_cnt <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        SIZE: begin
          NumData <= {NumData[SIZE_W-2:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  // Next-state decode and state-decoded / routed outputs.
  always_comb begin
    next_state = state;
    ldcntD     = 1'b0;
    cntD       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    dout       = 4'b0000;
    valid      = 4'b0000;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (clkEn && !sin) begin
          next_state = PORT;
        end else begin
          next_state = IDLE;
        end
      end
      PORT: begin
        if (clkEn && (bit_cnt == PORT_LAST)) begin
          next_state = SIZE;
        end else begin
          next_state = PORT;
        end
      end
      SIZE: begin
        if (clkEn && (bit_cnt == SIZE_LAST)) begin
          next_state = LOAD;
        end else begin
          next_state = SIZE;
        end
      end
      LOAD: begin
        // Counter loads on this edge; coD is meaningful from DATA onward.
        ldcntD     = 1'b1;
        next_state = DATA;
      end
      DATA: begin
        cntD = ~coD;
        for (int i = 0; i < NUM_CH; i++) begin
          if (port_sel == PORT_W'(i)) begin
            dout[i]  = sin & ~coD;
            valid[i] = clkEn & ~coD;
          end else begin
            dout[i]  = 1'b0;
            valid[i] = 1'b0;
          end
        end
        if (coD) begin
          next_state = DONE;
        end else begin
          next_state = DATA;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mssd_header_ctrl.sv
// Testbench for mssd_header_ctrl. Stimulus tasks send whole frames and push
// the expected header and per-bit routing results into queues; an
// independent negedge monitor pops and compares whenever the DUT strobes.
// The downstream data-transfer down-counter is modelled here as part of the
// environment.
module tb_mssd_header_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clkEn;
  logic       sin;
  logic       coD;
  logic       ldcntD;
  logic       cntD;
  logic [3:0] NumData;
  logic [1:0] port_sel;
  logic [3:0] dout;
  logic [3:0] valid;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  mssd_header_ctrl #(.PORT_W(2), .SIZE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clkEn    (clkEn),
    .sin      (sin),
    .coD      (coD),
    .ldcntD   (ldcntD),
    .cntD     (cntD),
    .NumData  (NumData),
    .port_sel (port_sel),
    .dout     (dout),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  // Downstream data-transfer counter: load on ldcntD, count on cntD&clkEn.
  logic [3:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 4'd0;
    else if (ldcntD) cnt <= NumData;
    else if (cntD && clkEn && cnt != 4'd0) cnt <= cnt - 4'd1;
  end
  assign coD = (cnt == 4'd0);

  // Reference model state: what every frame should produce.
  typedef struct { logic [1:0] port; logic data; } strobe_t;
  typedef struct { logic [1:0] port; logic [3:0] size; } hdr_t;
  strobe_t exp_strobes[$];
  hdr_t    exp_hdrs[$];
  int      exp_frames = 0;
  int      seen_done  = 0;
  int      checks     = 0;
  int      passes     = 0;
  logic [1:0] last_port = 2'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clk with the given enable/serial values, released 1 time unit after the edge.
  task automatic step(input logic en, input logic s);
    clkEn = en;
    sin   = s;
    @(posedge clk);
    #1;
  endtask

  // One serial bit preceded by 'gap' disabled clks carrying random line noise.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) step(1'b0, 1'($urandom_range(1, 0)));
    step(1'b1, b);
  endtask

  function automatic int pick_gap(input int mode);
    return (mode < 0) ? int'($urandom_range(3, 0)) : mode;
  endfunction

  // Send one full frame; gap<0 means random 0..3 disabled clks before each bit.
  // stall>0 freezes clkEn for that many clks after the first port bit.
  task automatic send_frame(input logic [1:0] p, input logic [3:0] n,
                            input logic [14:0] pl, input int gap, input int stall);
    hdr_t h;
    strobe_t s;
    h.port = p;
    h.size = n;
    exp_hdrs.push_back(h);
    for (int i = 0; i < int'(n); i++) begin
      s.port = p;
      s.data = pl[i];
      exp_strobes.push_back(s);
    end
    exp_frames++;
    send_bit(1'b0, pick_gap(gap));
    send_bit(p[1], pick_gap(gap));
    if (stall > 0) begin
      repeat (stall) step(1'b0, 1'($urandom_range(1, 0)));
      check("stall_port_sel", int'(port_sel), int'({last_port[0], p[1]}));
      check("stall_busy", int'(busy), 1);
    end
    send_bit(p[0], pick_gap(gap));
    for (int i = 3; i >= 0; i--) send_bit(n[i], pick_gap(gap));
    step(1'b0, 1'($urandom_range(1, 0)));  // LOAD slot, line ignored
    for (int i = 0; i < int'(n); i++) send_bit(pl[i], pick_gap(gap));
    // Count-out, DONE and return to IDLE, then one idle-high bit.
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    last_port = p;
  endtask

  // Monitor: compare DUT activity against the queued expectations.
  int      frame_strobes = 0;
  int      frame_size    = 0;
  logic    done_q        = 1'b0;
  hdr_t    h_mon;
  strobe_t s_mon;
  always @(negedge clk) begin
    if (rst) begin
      done_q = 1'b0;
    end else begin
      if (ldcntD) begin
        if (exp_hdrs.size() == 0) check("hdr_unexpected", 1, 0);
        else begin
          h_mon = exp_hdrs.pop_front();
          check("port_sel", int'(port_sel), int'(h_mon.port));
          check("NumData", int'(NumData), int'(h_mon.size));
          frame_size    = int'(h_mon.size);
          frame_strobes = 0;
        end
      end
      if (cntD) check("cntD_vs_coD", int'(coD), 0);
      if (valid != 4'b0000) begin
        check("valid_onehot", $countones(valid), 1);
        check("dout_unrouted", int'(dout & ~valid), 0);
        check("cntD_in_data", int'(cntD), 1);
        if (exp_strobes.size() == 0) check("strobe_unexpected", 1, 0);
        else begin
          s_mon = exp_strobes.pop_front();
          check("valid_chan", int'(valid), int'(4'b0001 << s_mon.port));
          check("dout_bit", int'(dout[s_mon.port]), int'(s_mon.data));
          frame_strobes++;
        end
      end
      if (done) begin
        seen_done++;
        check("done_width", int'(done_q), 0);
        check("strobes_per_frame", frame_strobes, frame_size);
      end
      done_q = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    clkEn = 1'b0;
    sin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ldcntD", int'(ldcntD), 0);
    check("rst_cntD", int'(cntD), 0);
    check("rst_NumData", int'(NumData), 0);
    check("rst_port_sel", int'(port_sel), 0);
    check("rst_valid", int'(valid), 0);
    rst = 1'b0;
    step(1'b0, 1'b1);

    // Idle line stays in IDLE.
    repeat (10) step(1'b1, 1'b1);
    check("idle_busy", int'(busy), 0);
    check("idle_port_sel", int'(port_sel), 0);

    // Nominal: clkEn every 4th clk, port 2, length 3, payload 1,0,1.
    send_frame(2'd2, 4'd3, 15'b000_0000_0000_0101, 3, 0);
    check("nom_busy", int'(busy), 0);
    check("nom_hold_port", int'(port_sel), 2);
    check("nom_hold_size", int'(NumData), 3);

    // Zero length on port 1.
    send_frame(2'd1, 4'd0, 15'd0, 1, 0);
    check("zero_busy", int'(busy), 0);
    check("zero_hold_size", int'(NumData), 0);

    // Maximum length on port 3.
    send_frame(2'd3, 4'd15, 15'($urandom), -1, 0);
    check("max_hold_size", int'(NumData), 15);

    // Stall 20 clks mid-PORT, then finish the frame.
    send_frame(2'd0, 4'd5, 15'($urandom), 0, 20);
    check("stall_frame_port", int'(port_sel), 0);

    // Reset in the middle of SIZE: frame dropped, no done.
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_NumData", int'(NumData), 0);
    check("mid_rst_port_sel", int'(port_sel), 0);
    check("mid_rst_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    last_port = 2'd0;
    step(1'b1, 1'b1);

    // Frame right after reset, then back-to-back random frames.
    send_frame(2'd1, 4'd2, 15'b000_0000_0000_0010, 0, 0);
    for (int f = 0; f < 20; f++) begin
      send_frame(2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)),
                 15'($urandom), -1, 0);
    end

    repeat (5) step(1'b0, 1'b1);
    check("end_busy", int'(busy), 0);
    check("strobes_left", exp_strobes.size(), 0);
    check("hdrs_left", exp_hdrs.size(), 0);
    check("done_count", seen_done, exp_frames);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
